// File: rtl/wb_regfile_if.sv
// wb_regfile_if: single-beat Wishbone B4 pipelined bus between the control-port master
// and the register bank slave.
interface wb_regfile_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  i_wb_cyc;
   logic                  i_wb_stb;
   logic                  i_wb_we;
   logic [ADDR_WIDTH-1:0] i_wb_addr;
   logic [31:0]           i_wb_data;
   logic [3:0]            i_wb_sel;
   logic                  o_wb_stall;
   logic                  o_wb_ack;
   logic [31:0]           o_wb_data;
   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      input  o_wb_stall, o_wb_ack, o_wb_data
   );
   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
      output o_wb_stall, o_wb_ack, o_wb_data
   );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: Wishbone B4 pipelined register bank with fixed ack latency.
// Define WB_REGFILE_RANDSTALL_EN to add an LFSR-driven random stall generator.
module wb_regfile #(
   parameter int                      ADDR_WIDTH   = 4,
   parameter int                      NUM_REGS     = 8,
   parameter int                      ACK_LATENCY  = 1,
   parameter logic [NUM_REGS*32-1:0]  RESET_VALUES = '0
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   wb_regfile_if.slave               wb,
   output logic [NUM_REGS*32-1:0]    o_regs,
   output logic [NUM_REGS-1:0]       o_wr_strobe
);
   logic [NUM_REGS-1:0][31:0]    regs_q, regs_d;
   logic [NUM_REGS-1:0]          strobe_q, strobe_d;
   logic [ACK_LATENCY-1:0]       vld_q, vld_d;
   logic [ACK_LATENCY-1:0][31:0] dat_q, dat_d;
   logic [31:0]                  rd_data;
   logic                         stall;
   logic                         acc;

   assign acc = wb.i_wb_cyc & wb.i_wb_stb & !stall;

   // Read data is taken from regs_q, so it always reflects the value before a same-edge write.
   always_comb begin
      rd_data  = '0;
      strobe_d = '0;
      regs_d   = regs_q;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (wb.i_wb_addr == ADDR_WIDTH'(k)) begin
            rd_data     = regs_q[k];
            strobe_d[k] = acc & wb.i_wb_we;
         end
         for (int b = 0; b < 4; b++)
            if (acc & wb.i_wb_we & wb.i_wb_sel[b] & (wb.i_wb_addr == ADDR_WIDTH'(k)))
               regs_d[k][8*b +: 8] = wb.i_wb_data[8*b +: 8];
      end
   end

   always_comb begin
      vld_d    = '0;
      dat_d    = '0;
      vld_d[0] = acc;
      dat_d[0] = (acc & !wb.i_wb_we) ? rd_data : '0;
      for (int i = 1; i < ACK_LATENCY; i++) begin
         vld_d[i] = wb.i_wb_cyc ? vld_q[i-1] : 1'b0;
         dat_d[i] = wb.i_wb_cyc ? dat_q[i-1] : '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         regs_q   <= RESET_VALUES;
         strobe_q <= '0;
         vld_q    <= '0;
         dat_q    <= '0;
      end else begin
         regs_q   <= regs_d;
         strobe_q <= strobe_d;
         vld_q    <= vld_d;
         dat_q    <= dat_d;
      end
   end

`ifdef WB_REGFILE_RANDSTALL_EN
   logic [15:0] lfsr_q, lfsr_d;
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   always_ff @(posedge i_clk) begin
      lfsr_q <= i_rst ? 16'hACE1 : lfsr_d;
   end
   assign stall = (lfsr_q[1:0] == 2'b00) & !i_rst;
`else
   assign stall = 1'b0;
`endif

   assign wb.o_wb_stall = stall;
   assign wb.o_wb_ack   = vld_q[ACK_LATENCY-1];
   assign wb.o_wb_data  = dat_q[ACK_LATENCY-1];
   assign o_regs        = regs_q;
   assign o_wr_strobe   = strobe_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of wb_regfile at ack latencies 1, 3 and 4
// (random-stall traffic against a register model when WB_REGFILE_RANDSTALL_EN is defined).
module tb_wb_regfile;
   localparam logic [255:0] RV3 = {128'h0, 32'h40, 32'h30, 32'h20, 32'h10};
   localparam logic [255:0] RV4 = {192'h0, 32'h101, 32'h0};

   logic         clk = 1'b0;
   logic         rst;
   logic         cyc, stb, we;
   logic [3:0]   addr, sel;
   logic [31:0]  wdat;
   logic [2:0]   who;
   logic [255:0] regs1, regs3, regs4;
   logic [7:0]   str1, str3, str4;
   int           checks = 0;
   int           errors = 0;
   int           n;

   wb_regfile_if #(.ADDR_WIDTH(4)) b1 ();
   wb_regfile_if #(.ADDR_WIDTH(4)) b3 ();
   wb_regfile_if #(.ADDR_WIDTH(4)) b4 ();

   assign b1.i_wb_cyc = cyc & (who == 3'd1);
   assign b1.i_wb_stb = stb & (who == 3'd1);
   assign b3.i_wb_cyc = cyc & (who == 3'd3);
   assign b3.i_wb_stb = stb & (who == 3'd3);
   assign b4.i_wb_cyc = cyc & (who == 3'd4);
   assign b4.i_wb_stb = stb & (who == 3'd4);
   assign b1.i_wb_we = we;
   assign b3.i_wb_we = we;
   assign b4.i_wb_we = we;
   assign b1.i_wb_addr = addr;
   assign b3.i_wb_addr = addr;
   assign b4.i_wb_addr = addr;
   assign b1.i_wb_data = wdat;
   assign b3.i_wb_data = wdat;
   assign b4.i_wb_data = wdat;
   assign b1.i_wb_sel = sel;
   assign b3.i_wb_sel = sel;
   assign b4.i_wb_sel = sel;

   wb_regfile #(.ADDR_WIDTH(4), .NUM_REGS(8), .ACK_LATENCY(1), .RESET_VALUES('0)) dut1 (
      .i_clk(clk), .i_rst(rst), .wb(b1), .o_regs(regs1), .o_wr_strobe(str1));
   wb_regfile #(.ADDR_WIDTH(4), .NUM_REGS(8), .ACK_LATENCY(3), .RESET_VALUES(RV3)) dut3 (
      .i_clk(clk), .i_rst(rst), .wb(b3), .o_regs(regs3), .o_wr_strobe(str3));
   wb_regfile #(.ADDR_WIDTH(4), .NUM_REGS(8), .ACK_LATENCY(4), .RESET_VALUES(RV4)) dut4 (
      .i_clk(clk), .i_rst(rst), .wb(b4), .o_regs(regs4), .o_wr_strobe(str4));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [2:0] w, input logic rw, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] s);
      who = w; cyc = 1'b1; stb = 1'b1; we = rw; addr = a; wdat = d; sel = s;
   endtask

   task automatic idle();
      stb = 1'b0; we = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

`ifdef WB_REGFILE_RANDSTALL_EN
   logic [31:0] m [8];
   logic        rw;
   logic [3:0]  ra, rs;
   logic [31:0] rv;
   int          accepts = 0;
   int          acks = 0;
`endif

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; sel = '0; wdat = '0; who = '0;
      repeat (2) tick();
      chk("rst_ack", b1.o_wb_ack, 1'b0);
      chk("rst_data", b1.o_wb_data, 32'h0);
      chk("rst_stall", b1.o_wb_stall, 1'b0);
      chk("rst_strobe", str1, 8'h0);
      chk("rst_regs1", regs1, 256'h0);
      chk("rst_regs3", regs3, RV3);
      chk("rst_regs4", regs4, RV4);
      rst = 1'b0;
      tick();
`ifdef WB_REGFILE_RANDSTALL_EN
      for (int k = 0; k < 8; k++) m[k] = '0;
      for (int t = 0; t < 1000; t++) begin
         rw = 1'($urandom); ra = 4'($urandom_range(0, 15)); rv = $urandom; rs = 4'($urandom);
         req(3'd1, rw, ra, rv, rs);
         n = 0;
         while (b1.o_wb_stall && n < 50) begin
            tick();
            n++;
            if (b1.o_wb_ack) acks++;
         end
         tick();
         accepts++;
         if (b1.o_wb_ack) acks++;
         if (!rw) chk("rand_rd", b1.o_wb_data, (ra < 4'd8) ? m[ra[2:0]] : 32'h0);
         else if (ra < 4'd8)
            for (int b = 0; b < 4; b++) if (rs[b]) m[ra[2:0]][8*b +: 8] = rv[8*b +: 8];
      end
      idle();
      tick();
      if (b1.o_wb_ack) acks++;
      chk("rand_acks", acks, accepts);
      for (int k = 0; k < 8; k++) chk("rand_regs", regs1[32*k +: 32], m[k]);
`else
      // latency 1: basic write/read
      req(3'd1, 1'b1, 4'd2, 32'hDEADBEEF, 4'hF);
      tick();
      chk("wr_ack", b1.o_wb_ack, 1'b1);
      chk("wr_strobe", str1, 8'b0000_0100);
      chk("wr_reg2", regs1[95:64], 32'hDEADBEEF);
      idle();
      tick();
      chk("wr_ack_drop", b1.o_wb_ack, 1'b0);
      chk("wr_strobe_drop", str1, 8'h0);
      req(3'd1, 1'b0, 4'd2, 32'h0, 4'hF);
      tick();
      chk("rd_reg2", {b1.o_wb_ack, b1.o_wb_data}, {1'b1, 32'hDEADBEEF});
      idle();
      tick();
      chk("rd_data_idle", {b1.o_wb_ack, b1.o_wb_data}, {1'b0, 32'h0});
      // byte enables, then read on the very next cycle
      req(3'd1, 1'b1, 4'd3, 32'h11223344, 4'hF);
      tick();
      req(3'd1, 1'b1, 4'd3, 32'hAABBCCDD, 4'b0101);
      tick();
      chk("sel_reg3", regs1[127:96], 32'h11BB33DD);
      req(3'd1, 1'b0, 4'd3, 32'h0, 4'hF);
      tick();
      chk("sel_rd3", {b1.o_wb_ack, b1.o_wb_data}, {1'b1, 32'h11BB33DD});
      // sel=0 still strobes, last valid register
      req(3'd1, 1'b1, 4'd5, 32'hFFFFFFFF, 4'h0);
      tick();
      chk("sel0_strobe", str1, 8'b0010_0000);
      chk("sel0_reg5", regs1[191:160], 32'h0);
      req(3'd1, 1'b1, 4'd7, 32'h12345678, 4'hF);
      tick();
      chk("last_strobe", str1, 8'b1000_0000);
      // out of range: first invalid index, then 12
      req(3'd1, 1'b0, 4'd8, 32'h0, 4'hF);
      tick();
      chk("oor_rd8", {b1.o_wb_ack, b1.o_wb_data}, {1'b1, 32'h0});
      req(3'd1, 1'b0, 4'd12, 32'h0, 4'hF);
      tick();
      chk("oor_rd12", {b1.o_wb_ack, b1.o_wb_data}, {1'b1, 32'h0});
      req(3'd1, 1'b1, 4'd12, 32'hFFFFFFFF, 4'hF);
      tick();
      chk("oor_wr_ack", b1.o_wb_ack, 1'b1);
      chk("oor_wr_strobe", str1, 8'h0);
      chk("oor_regs", regs1, {32'h12345678, 32'h0, 32'h0, 32'h0, 32'h11BB33DD, 32'hDEADBEEF, 64'h0});
      idle();
      tick();
      // latency 3: back-to-back reads
      req(3'd3, 1'b0, 4'd0, 32'h0, 4'hF);
      tick();
      chk("b2b_p1", b3.o_wb_ack, 1'b0);
      req(3'd3, 1'b0, 4'd1, 32'h0, 4'hF);
      tick();
      chk("b2b_p2", b3.o_wb_ack, 1'b0);
      req(3'd3, 1'b0, 4'd2, 32'h0, 4'hF);
      tick();
      chk("b2b_r0", {b3.o_wb_ack, b3.o_wb_data}, {1'b1, 32'h10});
      req(3'd3, 1'b0, 4'd3, 32'h0, 4'hF);
      tick();
      chk("b2b_r1", {b3.o_wb_ack, b3.o_wb_data}, {1'b1, 32'h20});
      idle();
      tick();
      chk("b2b_r2", {b3.o_wb_ack, b3.o_wb_data}, {1'b1, 32'h30});
      tick();
      chk("b2b_r3", {b3.o_wb_ack, b3.o_wb_data}, {1'b1, 32'h40});
      tick();
      chk("b2b_end", {b3.o_wb_ack, b3.o_wb_data}, {1'b0, 32'h0});
      // write behind an in-flight read to the same address
      req(3'd3, 1'b0, 4'd0, 32'h0, 4'hF);
      tick();
      req(3'd3, 1'b1, 4'd0, 32'hCAFEF00D, 4'hF);
      tick();
      idle();
      tick();
      chk("raw_old", {b3.o_wb_ack, b3.o_wb_data}, {1'b1, 32'h10});
      tick();
      chk("raw_wr_ack", b3.o_wb_ack, 1'b1);
      tick();
      req(3'd3, 1'b0, 4'd0, 32'h0, 4'hF);
      tick();
      idle();
      tick();
      tick();
      chk("raw_new", {b3.o_wb_ack, b3.o_wb_data}, {1'b1, 32'hCAFEF00D});
      tick();
      // cyc drop flushes in-flight acks
      req(3'd3, 1'b0, 4'd1, 32'h0, 4'hF);
      tick();
      req(3'd3, 1'b0, 4'd2, 32'h0, 4'hF);
      tick();
      cyc = 1'b0;
      idle();
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (b3.o_wb_ack) n++;
      end
      chk("cyc_drop_acks", n, 0);
      req(3'd3, 1'b0, 4'd3, 32'h0, 4'hF);
      tick();
      idle();
      n = 0;
      while (!b3.o_wb_ack && n < 8) begin
         tick();
         n++;
      end
      chk("post_drop_rd", {b3.o_wb_ack, b3.o_wb_data}, {1'b1, 32'h40});
      chk("post_drop_lat", n, 2);
      tick();
      // latency 4: reset one cycle after a write accept
      req(3'd4, 1'b1, 4'd1, 32'h55, 4'hF);
      tick();
      chk("pre_rst_reg1", regs4[63:32], 32'h55);
      chk("pre_rst_ack", b4.o_wb_ack, 1'b0);
      rst = 1'b1;
      req(3'd4, 1'b1, 4'd2, 32'h77, 4'hF);
      tick();
      chk("rst_mid_regs", regs4, RV4);
      chk("rst_mid_strobe", str4, 8'h0);
      rst = 1'b0;
      idle();
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (b4.o_wb_ack) n++;
      end
      chk("rst_mid_acks", n, 0);
      chk("rst_mid_regs_after", regs4, RV4);
      chk("rst_regs1_cleared", regs1, 256'h0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
